serial_product_receiver: RTL and testbench
==========================================

# serial_product_receiver

Deserializer at the output end of the serial multiplier datapath. It collects the serial product bit stream, one bit per qualified clock, into a parallel word of WIDTH bits. It presents the finished word through a single-entry valid/ready output buffer. It is the receiving counterpart of the serial-out shift registers: it accepts bits in the order they shift out, MSB first by default.

## Interface
- WIDTH, 8, number of bits per frame / product width (≥2)
- MSB_FIRST, 1, 1: first received bit lands in Out[WIDTH-1]; 0: first received bit lands in Out[0]
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-low reset
- START  input  1  begin new frame (pulse)
- In  input  1  serial data bit
- InValid  input  1  In is valid this cycle
- Out  output  WIDTH  assembled word (buffer contents)
- OutValid  output  1  Out holds an unconsumed word
- OutReady  input  1  consumer accepts Out this cycle
- Busy  output  1  frame collection in progress
- BitCnt  output  $clog2(WIDTH+1)  bits collected in current frame
- Overrun  output  1  sticky: a completed frame was dropped

## Operation
- Reset (RST=0, asynchronous): state IDLE; shift register, Out, BitCnt = 0; OutValid, Busy, Overrun = 0.
- FSM states: IDLE, SHIFT.
- IDLE: InValid ignored. START=1 → SHIFT, BitCnt←0, shift register←0.
- SHIFT, START=0, InValid=1 → shift In in, BitCnt+1.
  - MSB_FIRST=1: sr←{sr[WIDTH-2:0],In}.
  - MSB_FIRST=0: sr←{In,sr[WIDTH-1:1]}.
- SHIFT, START=0, InValid=0 → hold; no timeout.
- Frame completion: the InValid cycle with BitCnt==WIDTH-1 completes the frame.
  - The completed word (including that bit) is offered to the output buffer.
  - FSM → IDLE; BitCnt←0.
- START in SHIFT aborts the partial frame: bits discarded, BitCnt←0, stays SHIFT. START has priority over InValid; the In bit in a START cycle is never sampled, in any state.
- Output buffer, single entry, evaluated on the completion edge:
  - If OutValid=0, or OutValid=1 and OutReady=1: Out←word, OutValid←1.
  - If OutValid=1 and OutReady=0: word dropped, Out unchanged, Overrun←1.
- No completion: OutValid=1 and OutReady=1 → OutValid←0. Out keeps its last value.
- OutReady while OutValid=0 has no effect.
- Overrun clears only on reset.
- Busy = (state==SHIFT).
- Out never changes while OutValid=1 except on a same-cycle consume-and-reload.

## Timing
- All outputs are registered; no combinational input→output path.
- START at edge k → Busy=1 after edge k; first sampled bit at edge k+1 at the earliest.
- Latency: last bit sampled at edge n → Out/OutValid updated after edge n. Minimum frame is WIDTH+1 cycles including the START cycle.
- Back-to-back frames: START may be asserted in the cycle after completion. It may also coincide with OutValid=1; collection proceeds independently of the buffer.
- Consume handshake: transfer occurs on an edge where OutValid=1 and OutReady=1; OutValid falls after that edge unless reloaded on the same edge.
- Reset mid-frame or with OutValid=1: all state is lost immediately (asynchronous); the first valid action after release is a START.

## Test plan
- WIDTH=8, MSB_FIRST=1: START, then bits 1,0,1,1,0,1,0,0 on consecutive cycles, OutReady=0 → Out=8'hB4, OutValid=1 after the 8th bit edge, Busy=0, BitCnt=0, Overrun=0.
- MSB_FIRST=0, same stream → Out=8'h2D. Gaps of InValid=0 inserted between bits give an identical result, and BitCnt increments only on valid bits.
- Abort: START, 5 bits, START, then bits of 8'hC3 → Out=8'hC3; the partial bits have no effect. A bit presented with InValid=1 during a START cycle is ignored.
- Overrun:
  - Frame 8'hB4 arrives, OutReady held 0, then frame 8'h5A arrives → Out stays 8'hB4, Overrun=1.
  - OutReady=1 → OutValid=0 next edge; Overrun stays 1.
- Consume-and-reload: OutValid=1 (8'hB4) with OutReady=1 on the completion edge of 8'h0F → Out=8'h0F, OutValid stays 1, Overrun=0.
- Reset: RST=0 asynchronously mid-frame (BitCnt=3) with OutValid=1 → all outputs 0 immediately, without waiting for a CLK edge. After release, InValid bits without START → no change.

Source files
------------

// File: rtl/serial_product_receiver.sv
// Serial-to-parallel receiver for the multiplier product stream.
// Collects WIDTH qualified bits per frame and hands the word to a one-entry valid/ready buffer.
module serial_product_receiver #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic                         In,
    input  logic                         InValid,
    output logic [WIDTH-1:0]             Out,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic                         Busy,
    output logic [$clog2(WIDTH+1)-1:0]   BitCnt,
    output logic                         Overrun
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state, state_d;
    logic [WIDTH-1:0] sr, sr_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] out_d;
    logic             out_valid_d;
    logic             overrun_d;
    logic             complete;

    // Shift register with the incoming bit folded in, in the configured bit order
    always_comb begin
        if (MSB_FIRST != 0) shifted = {sr[WIDTH-2:0], In};
        else                shifted = {In, sr[WIDTH-1:1]};
    end

    // Next-state: frame collection and output buffer
    always_comb begin
        state_d     = state;
        sr_d        = sr;
        cnt_d       = BitCnt;
        out_d       = Out;
        out_valid_d = OutValid;
        overrun_d   = Overrun;
        complete    = 1'b0;

        case (state)
            IDLE: begin
                if (START) begin
                    state_d = SHIFT;
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // START restarts the frame and masks the bit presented with it
                if (START) begin
                    sr_d  = '0;
                    cnt_d = '0;
                end else if (InValid) begin
                    sr_d = shifted;
                    if (BitCnt == CW'(WIDTH - 1)) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = BitCnt + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (complete) begin
            if (!OutValid || OutReady) begin
                out_d       = shifted;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (OutValid && OutReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            sr       <= '0;
            BitCnt   <= '0;
            Out      <= '0;
            OutValid <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            state    <= state_d;
            sr       <= sr_d;
            BitCnt   <= cnt_d;
            Out      <= out_d;
            OutValid <= out_valid_d;
            Overrun  <= overrun_d;
        end
    end

    assign Busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_product_receiver.sv
// Bench for serial_product_receiver: MSB-first and LSB-first instances share one stimulus
// and are checked every cycle against a queue-based frame model, plus literal expectations.
module tb_serial_product_receiver;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          din = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;

    logic [W-1:0]  out1, out0;
    logic          ov1, ov0, busy1, busy0, orun1, orun0;
    logic [CW-1:0] cnt1, cnt0;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model: bits of the current frame in arrival order, plus the buffer
    bit        m_busy;
    bit        bits[$];
    bit        m_valid;
    bit        m_orun;
    bit [W-1:0] m_out1, m_out0;

    always #5 clk = ~clk;

    serial_product_receiver #(.WIDTH(W), .MSB_FIRST(1)) dut1 (
        .CLK(clk), .RST(rst_n), .START(start), .In(din), .InValid(in_valid),
        .Out(out1), .OutValid(ov1), .OutReady(out_ready), .Busy(busy1),
        .BitCnt(cnt1), .Overrun(orun1)
    );

    serial_product_receiver #(.WIDTH(W), .MSB_FIRST(0)) dut0 (
        .CLK(clk), .RST(rst_n), .START(start), .In(din), .InValid(in_valid),
        .Out(out0), .OutValid(ov0), .OutReady(out_ready), .Busy(busy0),
        .BitCnt(cnt0), .Overrun(orun0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        bits.delete();
        m_valid = 1'b0;
        m_orun  = 1'b0;
        m_out1  = '0;
        m_out0  = '0;
    endtask

    // Advance the model by one clock using the inputs held across that edge
    task automatic model_step();
        bit         done;
        bit [W-1:0] w1, w0;
        done = 1'b0;
        w1 = '0;
        w0 = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (start) begin
            m_busy = 1'b1;
            bits.delete();
        end else if (m_busy && in_valid) begin
            bits.push_back(din);
            if (bits.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    w1[W-1-i] = bits[i];
                    w0[i]     = bits[i];
                end
                done   = 1'b1;
                m_busy = 1'b0;
                bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || out_ready) begin
                m_valid = 1'b1;
                m_out1  = w1;
                m_out0  = w0;
            end else begin
                m_orun = 1'b1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit st, input bit b, input bit v, input bit rdy);
        start     = st;
        din       = b;
        in_valid  = v;
        out_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Sends a frame as a bit stream, first transmitted bit = w[W-1]; OutReady given only on the last bit
    task automatic send_frame(input bit [W-1:0] w, input bit rdy_last, input bit gaps);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (gaps && (i % 2 == 1)) begin
                step(1'b0, ~w[W-1-i], 1'b0, 1'b0);
                step(1'b0, ~w[W-1-i], 1'b0, 1'b0);
            end
            step(1'b0, w[W-1-i], 1'b1, (i == W - 1) ? rdy_last : 1'b0);
            if (gaps) check("gap_bitcnt", 32'(cnt1), (i == W - 1) ? 32'd0 : 32'(i + 1));
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_msb",    32'(out1),  32'(m_out1));
            check("out_lsb",    32'(out0),  32'(m_out0));
            check("outvalid1",  32'(ov1),   32'(m_valid));
            check("outvalid0",  32'(ov0),   32'(m_valid));
            check("busy1",      32'(busy1), 32'(m_busy));
            check("busy0",      32'(busy0), 32'(m_busy));
            check("bitcnt1",    32'(cnt1),  32'(bits.size()));
            check("bitcnt0",    32'(cnt0),  32'(bits.size()));
            check("overrun1",   32'(orun1), 32'(m_orun));
            check("overrun0",   32'(orun0), 32'(m_orun));
        end
    end

    initial begin
        model_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_out",      32'(out1),  32'h0);
        check("rst_outvalid", 32'(ov1),   32'h0);
        check("rst_busy",     32'(busy1), 32'h0);
        check("rst_bitcnt",   32'(cnt1),  32'h0);
        check("rst_overrun",  32'(orun1), 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Basic frame, both bit orders
        send_frame(8'hB4, 1'b0, 1'b0);
        check("b4_msb",      32'(out1),  32'hB4);
        check("b4_lsb",      32'(out0),  32'h2D);
        check("b4_valid",    32'(ov1),   32'h1);
        check("b4_busy",     32'(busy1), 32'h0);
        check("b4_bitcnt",   32'(cnt1),  32'h0);
        check("b4_overrun",  32'(orun1), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("consume_valid", 32'(ov1),  32'h0);
        check("consume_keep",  32'(out1), 32'hB4);

        // Same stream with InValid gaps
        send_frame(8'hB4, 1'b0, 1'b1);
        check("gap_msb", 32'(out1), 32'hB4);
        check("gap_lsb", 32'(out0), 32'h2D);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Abort after 5 bits; the bit offered with the restarting START is ignored
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        check("abort_cnt5", 32'(cnt1), 32'd5);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("abort_cnt0", 32'(cnt1), 32'd0);
        check("abort_busy", 32'(busy1), 32'h1);
        for (int i = 0; i < W; i++) begin
            automatic bit [W-1:0] c3 = 8'hC3;
            step(1'b0, c3[W-1-i], 1'b1, 1'b0);
        end
        check("abort_msb", 32'(out1), 32'hC3);
        check("abort_lsb", 32'(out0), 32'hC3);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun: second frame dropped while buffer is held
        send_frame(8'hB4, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        check("orun_keep",  32'(out1),  32'hB4);
        check("orun_flag",  32'(orun1), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("orun_drain", 32'(ov1),   32'h0);
        check("orun_stick", 32'(orun1), 32'h1);

        // Asynchronous reset mid-frame with a word buffered
        send_frame(8'hB4, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        check("pre_rst_cnt", 32'(cnt1), 32'd3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_out",     32'(out1),  32'h0);
        check("arst_valid",   32'(ov1),   32'h0);
        check("arst_busy",    32'(busy1), 32'h0);
        check("arst_bitcnt",  32'(cnt1),  32'h0);
        check("arst_overrun", 32'(orun1), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        check("norst_cnt",   32'(cnt1), 32'd0);
        check("norst_valid", 32'(ov1),  32'h0);

        // Consume-and-reload on the completion edge
        send_frame(8'hB4, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        check("reload_msb",   32'(out1),  32'h0F);
        check("reload_lsb",   32'(out0),  32'hF0);
        check("reload_valid", 32'(ov1),   32'h1);
        check("reload_orun",  32'(orun1), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
